// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data memory with fixed access latency and
// registered, handshake-held response (misaligned/out-of-range requests flagged as errors).
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mem_we;
  logic        bad;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];
  assign idx        = addr_q[AW+1:2];
  assign bad        = (|addr_q[1:0]) | (|addr_q[31:AW+2]);
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = BUSY;
        cnt_d   = 4'(LATENCY - 1);
        we_d    = req_we;
        addr_d  = req_addr;
        wdata_d = req_wdata;
      end
      BUSY: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        state_d = RESP;
        err_d   = bad;
        rdata_d = (bad || we_q) ? 32'd0 : mem[idx];
        mem_we  = we_q && !bad;
      end
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // Array is deliberately not reset; a reset in flight must still suppress the commit.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[idx] <= wdata_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks against a word-array reference model.
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam int LATENCY = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;
  logic l1_req_valid = 1'b0, l1_req_ready, l1_req_we = 1'b0;
  logic [31:0] l1_req_addr = '0, l1_req_wdata = '0;
  logic l1_resp_valid, l1_resp_ready = 1'b0, l1_resp_err;
  logic [31:0] l1_resp_rdata;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] ref_mem [DEPTH];
  bit known [DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err));

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_we(l1_req_we),
    .req_addr(l1_req_addr), .req_wdata(l1_req_wdata), .resp_valid(l1_resp_valid),
    .resp_ready(l1_resp_ready), .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction; req_valid stays high with junk while busy to prove it is ignored.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic bad;
    logic [31:0] held;
    int k;
    bad = (addr[1:0] != 2'd0) || (addr[31:2] >= DEPTH);
    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    k = 0;
    while (k <= 40) begin
      @(negedge clk);
      if (resp_valid) break;
      check("ready_busy", {31'd0, req_ready}, 32'd0);
      k++;
    end
    check("latency", k, LATENCY);
    check("err", {31'd0, resp_err}, {31'd0, bad});
    if (bad || we) check("rdata_zero", resp_rdata, 32'd0);
    else if (known[addr[7:2]]) check("rdata", resp_rdata, ref_mem[addr[7:2]]);
    if (we && !bad) begin
      ref_mem[addr[7:2]] = wdata;
      known[addr[7:2]] = 1'b1;
    end
    held = resp_rdata;
    repeat (hold) begin
      @(negedge clk);
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, held);
      check("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("hs_valid", {31'd0, resp_valid}, 32'd0);
    check("hs_ready", {31'd0, req_ready}, 32'd1);
    check("hs_hold", resp_rdata, held);
    resp_ready = 1'b0;
  endtask

  initial begin
    int w;
    #2;
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk) rst = 1'b0;
    xact(1'b1, 32'h10, 32'hDEADBEEF, 0);
    xact(1'b0, 32'h10, 32'h0, 0);
    check("ld_after_st", ref_mem[4], 32'hDEADBEEF);
    xact(1'b1, 32'h12, 32'h55555555, 0);
    xact(1'b0, 32'h10, 32'h0, 0);
    xact(1'b0, 32'h100, 32'h0, 0);
    xact(1'b0, 32'h10, 32'h0, 5);
    xact(1'b1, 32'h20, 32'h0, 0);
    // Reset during the first BUSY cycle abandons the store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    #1 check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_nores", {31'd0, resp_valid}, 32'd0);
    xact(1'b0, 32'h20, 32'h0, 0);
    // Reset while a response is pending drops it.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    w = 0;
    while (!resp_valid && w < 40) begin @(negedge clk); w++; end
    check("resp_before_rst", {31'd0, resp_valid}, 32'd1);
    rst = 1'b1;
    #1 check("resprst_valid", {31'd0, resp_valid}, 32'd0);
    check("resprst_rdata", resp_rdata, 32'd0);
    check("resprst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = {24'd0, 3'($urandom_range(0, 7)), 2'b00} + 32'h40;
      if (kind == 8) a = a | 32'($urandom_range(1, 3));
      if (kind == 9) a = 32'($urandom_range(DEPTH, 4000)) << 2;
      xact(1'($urandom), a, $urandom, $urandom_range(0, 3));
    end
    // LATENCY=1 instance.
    @(negedge clk);
    l1_req_valid = 1'b1; l1_req_we = 1'b1; l1_req_addr = 32'h8; l1_req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    l1_req_valid = 1'b0;
    check("l1_busy", {31'd0, l1_resp_valid}, 32'd0);
    @(negedge clk);
    check("l1_valid", {31'd0, l1_resp_valid}, 32'd1);
    check("l1_st_err", {31'd0, l1_resp_err}, 32'd0);
    l1_resp_ready = 1'b1;
    @(negedge clk);
    l1_resp_ready = 1'b0;
    l1_req_valid = 1'b1; l1_req_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    l1_req_valid = 1'b0;
    @(negedge clk);
    check("l1_ld_valid", {31'd0, l1_resp_valid}, 32'd1);
    check("l1_ld_rdata", l1_resp_rdata, 32'hCAFEF00D);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the internal data array; legal values are powers of two from 4 to 1024.
REQ-002 Parameter LATENCY, default 2: cycles from request accept to response; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  core presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store (memWr), 0 = load (memRe).
REQ-008 req_addr  input  32  byte address; this is the ALU result from the core.
REQ-009 req_wdata  input  32  store data; this is the second register operand from the core.
REQ-010 resp_valid  output  1  response is available.
REQ-011 resp_ready  input  1  core consumes the response.
REQ-012 resp_rdata  output  32  load data.
REQ-013 resp_err  output  1  the request was misaligned or out of range.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, BUSY and RESP, encoded in 2 bits.
REQ-015 req_ready SHALL be 1 only in IDLE, and SHALL depend combinationally on state only.
REQ-016 Accept: on a clock edge in IDLE with req_valid=1, the block SHALL latch req_we, req_addr and req_wdata, load wait counter = LATENCY-1, and go to BUSY.
REQ-017 In IDLE with req_valid=0, the block SHALL remain in IDLE; latched registers hold.
REQ-018 In BUSY with counter!=0, the counter SHALL decrement; with counter=0, the access SHALL commit on that edge and the state SHALL go to RESP.
REQ-019 Latency: for an accept at edge N, resp_valid SHALL first be 1 after edge N+LATENCY.
REQ-020 Word index SHALL be latched_addr[31:2]; the request is an error if latched_addr[1:0]!=0 or word index >= DEPTH.
REQ-021 Valid store: mem[index] SHALL be written with latched wdata at the commit edge; resp_rdata SHALL be 0 and resp_err SHALL be 0.
REQ-022 Valid load: resp_rdata SHALL be registered mem[index] captured at the commit edge; resp_err SHALL be 0.
REQ-023 Error request: memory SHALL NOT be written; resp_rdata SHALL be 0 and resp_err SHALL be 1.
REQ-024 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_err SHALL be held stable until handshake.
REQ-025 When resp_valid=1 and resp_ready=1 at an edge, the state SHALL go to IDLE; otherwise it SHALL stay in RESP indefinitely.
REQ-026 req_valid SHALL be ignored outside IDLE; there is no queuing, and the minimum request-to-request period is LATENCY+2 cycles.
REQ-027 A load that follows a store to the same word SHALL return the stored value.
REQ-028 resp_valid SHALL be 0 in IDLE and BUSY; resp_rdata and resp_err SHALL hold their last values outside RESP.

Reset
REQ-029 While rst=1, the state SHALL be IDLE, counter 0, latched registers 0, resp_rdata 0 and resp_err 0; resp_valid SHALL be 0 and req_ready SHALL be 1 after reset release.
REQ-030 Reset SHALL NOT clear the memory array; its contents are undefined until written.
REQ-031 Reset asserted in BUSY before the commit edge SHALL abandon the request with no memory write.
REQ-032 Reset asserted in RESP SHALL drop the pending response without requiring a handshake.

Verification (DEPTH=64, LATENCY=2)
REQ-033 Store: addr 0x10, wdata 0xDEADBEEF, accept at edge N -> resp_valid=1 after edge N+2 with resp_err=0 and resp_rdata=0; resp_ready=1 -> IDLE.
REQ-034 Load after store: load from addr 0x10 -> resp_rdata=0xDEADBEEF and resp_err=0, appearing 2 cycles after accept.
REQ-035 Errors: store to addr 0x12 -> resp_err=1 and word 4 unchanged; load from addr 0x100 (index 64) -> resp_err=1 and resp_rdata=0.
REQ-036 Backpressure: hold resp_ready=0 for 5 cycles with req_valid=1 -> resp_valid, resp_rdata and req_ready=0 all stable; the second request is accepted only after handshake plus return to IDLE.
REQ-037 Reset mid-op: store 0x12345678 to 0x20, assert rst in the first BUSY cycle -> immediate IDLE with req_ready=1, and a later load of 0x20 does not return 0x12345678 (preload 0).
REQ-038 LATENCY=1 regression: accept at edge N -> resp_valid=1 after edge N+1.
